// File: rtl/controller_decoder_pkg.sv
// Shared definitions for the controller decoder: controls-word bit map,
// stick code classes and the per-axis flick FSM encoding.
package controller_decoder_pkg;

    localparam int unsigned CTRL_W  = 32;
    localparam int unsigned CODE_W  = 3;

    // Controls word bit map
    localparam int unsigned BIT_FACING  = 26;
    localparam int unsigned BIT_SMASH_L = 23;
    localparam int unsigned BIT_SMASH_R = 22;
    localparam int unsigned BIT_SMASH_U = 21;
    localparam int unsigned BIT_SMASH_D = 20;
    localparam int unsigned BIT_SHIELD  = 19;
    localparam int unsigned BIT_JUMP    = 18;
    localparam int unsigned BIT_B       = 17;
    localparam int unsigned BIT_A       = 16;
    localparam int unsigned X_CODE_LSB  = 13;
    localparam int unsigned Y_CODE_LSB  = 5;

    localparam logic [CTRL_W-1:0] CONTROLS_RESET = 32'h0400_8080;

    // Stick code classes
    localparam logic [CODE_W-1:0] NEUTRAL_LO = 3'b011;
    localparam logic [CODE_W-1:0] NEUTRAL_HI = 3'b100;
    localparam logic [CODE_W-1:0] EXTREME_LO = 3'b000;
    localparam logic [CODE_W-1:0] EXTREME_HI = 3'b111;

    typedef enum logic [1:0] {
        AXIS_IDLE  = 2'd0,
        AXIS_MOVE  = 2'd1,
        AXIS_ARMED = 2'd2,
        AXIS_HELD  = 2'd3
    } axis_state_e;

    function automatic logic is_neutral(input logic [CODE_W-1:0] code);
        return (code == NEUTRAL_LO) || (code == NEUTRAL_HI);
    endfunction

    function automatic logic is_extreme(input logic [CODE_W-1:0] code);
        return (code == EXTREME_LO) || (code == EXTREME_HI);
    endfunction

endpackage

// File: rtl/controller_decoder_button_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a stability counter.
// The debounced level flips only after the synchronised input has differed
// from it for DEBOUNCE_CYCLES consecutive clocks; any bounce restarts the count.
// Ports: clock, reset (async active-low), btn_raw_i (asynchronous raw button),
//        btn_o (debounced level).
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw_i,
    output logic btn_o
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchroniser, counter and level registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Count consecutive disagreeing clocks; flip on the last one
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign btn_o = level_q;

endmodule

// File: rtl/controller_decoder.sv
// Converts sampled stick X/Y and four raw buttons into the 32-bit controls
// word: debounced buttons, 3-bit stick codes, facing and smash detection
// (stick flick to an extreme followed by a fresh A press).
// Ports: clock, reset (async active-low), sample_valid (new stick sample strobe),
//        joy_x/joy_y (8-bit stick), btn_*_raw (raw buttons),
//        controls (registered word), controls_valid (pulse on update).
module controller_decoder
    import controller_decoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned FLICK_SAMPLES   = 3,
    parameter int unsigned SMASH_WINDOW    = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [7:0]        joy_x,
    input  logic [7:0]        joy_y,
    input  logic              btn_a_raw,
    input  logic              btn_b_raw,
    input  logic              btn_jump_raw,
    input  logic              btn_shield_raw,
    output logic [CTRL_W-1:0] controls,
    output logic              controls_valid
);

    localparam int unsigned CNT_W = $clog2(FLICK_SAMPLES + 1);
    localparam int unsigned WIN_W = $clog2(SMASH_WINDOW + 1);

    logic a_deb, b_deb, jump_deb, shield_deb;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
        .clock(clock), .reset(reset), .btn_raw_i(btn_a_raw), .btn_o(a_deb));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
        .clock(clock), .reset(reset), .btn_raw_i(btn_b_raw), .btn_o(b_deb));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_jump (
        .clock(clock), .reset(reset), .btn_raw_i(btn_jump_raw), .btn_o(jump_deb));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_shield (
        .clock(clock), .reset(reset), .btn_raw_i(btn_shield_raw), .btn_o(shield_deb));

    // Only the top three bits of each stick sample form the code
    logic unused_joy_lsbs;
    assign unused_joy_lsbs = ^{joy_x[4:0], joy_y[4:0]};

    logic [CODE_W-1:0] code_c [2];
    assign code_c[0] = joy_x[7:5];
    assign code_c[1] = joy_y[7:5];

    logic [1:0]        armed_c;    // per axis: currently ARMED
    logic [1:0]        consume_c;  // per axis: smash fires from this axis
    logic [CODE_W-1:0] dir_c [2];  // per axis: recorded extreme

    // Per-axis flick FSM (index 0 = X, 1 = Y)
    for (genvar i = 0; i < 2; i++) begin : g_axis
        axis_state_e       state_q, state_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic [WIN_W-1:0]  win_q, win_d;
        logic [CODE_W-1:0] dir_q, dir_d;
        logic              axis_armed_c;

        // State register
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state_q <= AXIS_IDLE;
                cnt_q   <= '0;
                win_q   <= '0;
                dir_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                win_q   <= win_d;
                dir_q   <= dir_d;
            end
        end

        // Next state; neutral always returns to IDLE
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            win_d   = win_q;
            dir_d   = dir_q;
            if (sample_valid) begin
                if (is_neutral(code_c[i])) begin
                    state_d = AXIS_IDLE;
                end else begin
                    unique case (state_q)
                        AXIS_IDLE: begin
                            if (is_extreme(code_c[i])) begin
                                state_d = AXIS_ARMED;
                                win_d   = WIN_W'(SMASH_WINDOW);
                                dir_d   = code_c[i];
                            end else begin
                                state_d = AXIS_MOVE;
                                cnt_d   = CNT_W'(1);
                            end
                        end
                        AXIS_MOVE: begin
                            if (is_extreme(code_c[i])) begin
                                if (cnt_q < CNT_W'(FLICK_SAMPLES)) begin
                                    state_d = AXIS_ARMED;
                                    win_d   = WIN_W'(SMASH_WINDOW);
                                    dir_d   = code_c[i];
                                end else begin
                                    state_d = AXIS_HELD;
                                end
                            end else if (cnt_q < CNT_W'(FLICK_SAMPLES)) begin
                                cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                        AXIS_ARMED: begin
                            win_d = win_q - WIN_W'(1);
                            if (consume_c[i] || (code_c[i] != dir_q) || (win_d == '0)) begin
                                state_d = AXIS_HELD;
                            end
                        end
                        AXIS_HELD: state_d = AXIS_HELD;
                        default:   state_d = AXIS_IDLE;
                    endcase
                end
            end
        end

        // Outputs
        always_comb begin
            axis_armed_c = (state_q == AXIS_ARMED);
        end

        assign armed_c[i] = axis_armed_c;
        assign dir_c[i]   = dir_q;
    end

    logic              a_prev_q, a_prev_d;
    logic              a_mask_q, a_mask_d;
    logic              facing_q, facing_d;
    logic [CTRL_W-1:0] controls_q, controls_d;
    logic              controls_valid_q;
    logic              a_edge_c, smash_c;
    logic [CTRL_W-1:0] word_c;

    // Smash arbitration (X wins) and controls word assembly
    always_comb begin
        a_edge_c  = a_deb & ~a_prev_q;
        consume_c = '0;
        if (a_edge_c) begin
            if (armed_c[0])      consume_c = 2'b01;
            else if (armed_c[1]) consume_c = 2'b10;
        end
        smash_c = |consume_c;

        facing_d = facing_q;
        a_prev_d = a_prev_q;
        a_mask_d = a_mask_q;
        if (sample_valid) begin
            if (code_c[0] == EXTREME_LO)      facing_d = 1'b0;
            else if (code_c[0] == EXTREME_HI) facing_d = 1'b1;
            a_prev_d = a_deb;
            // A stays masked after a smash until it is seen released
            if (smash_c)     a_mask_d = 1'b1;
            else if (!a_deb) a_mask_d = 1'b0;
        end

        word_c                             = '0;
        word_c[BIT_FACING]                 = facing_d;
        word_c[BIT_SMASH_L]                = consume_c[0] & (dir_c[0] == EXTREME_LO);
        word_c[BIT_SMASH_R]                = consume_c[0] & (dir_c[0] == EXTREME_HI);
        word_c[BIT_SMASH_U]                = consume_c[1] & (dir_c[1] == EXTREME_HI);
        word_c[BIT_SMASH_D]                = consume_c[1] & (dir_c[1] == EXTREME_LO);
        word_c[BIT_SHIELD]                 = shield_deb;
        word_c[BIT_JUMP]                   = jump_deb;
        word_c[BIT_B]                      = b_deb;
        word_c[BIT_A]                      = a_deb & ~a_mask_q & ~smash_c;
        word_c[X_CODE_LSB +: CODE_W]       = code_c[0];
        word_c[Y_CODE_LSB +: CODE_W]       = code_c[1];

        controls_d = sample_valid ? word_c : controls_q;
    end

    // Output and tracking registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            controls_q       <= CONTROLS_RESET;
            controls_valid_q <= 1'b0;
            facing_q         <= 1'b1;
            a_prev_q         <= 1'b0;
            a_mask_q         <= 1'b0;
        end else begin
            controls_q       <= controls_d;
            controls_valid_q <= sample_valid;
            facing_q         <= facing_d;
            a_prev_q         <= a_prev_d;
            a_mask_q         <= a_mask_d;
        end
    end

    assign controls       = controls_q;
    assign controls_valid = controls_valid_q;

endmodule

// File: tb/tb_controller_decoder.sv
// Bench for controller_decoder: directed scenarios followed by random stick
// bursts, all checked against a queue-based behavioural model of the controls word.
module tb_controller_decoder;

    localparam int unsigned DEB   = 64;
    localparam int unsigned FLICK = 3;
    localparam int unsigned WIN   = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic [7:0]  joy_x = 8'd128;
    logic [7:0]  joy_y = 8'd128;
    logic        btn_a_raw = 1'b0;
    logic        btn_b_raw = 1'b0;
    logic        btn_jump_raw = 1'b0;
    logic        btn_shield_raw = 1'b0;
    logic [31:0] controls;
    logic        controls_valid;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    controller_decoder #(
        .DEBOUNCE_CYCLES(DEB),
        .FLICK_SAMPLES  (FLICK),
        .SMASH_WINDOW   (WIN)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .sample_valid  (sample_valid),
        .joy_x         (joy_x),
        .joy_y         (joy_y),
        .btn_a_raw     (btn_a_raw),
        .btn_b_raw     (btn_b_raw),
        .btn_jump_raw  (btn_jump_raw),
        .btn_shield_raw(btn_shield_raw),
        .controls      (controls),
        .controls_valid(controls_valid)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_word;
    bit          m_facing, m_a, m_b, m_jump, m_shield, m_a_prev, m_mask;
    logic [2:0]  run_x[$];
    logic [2:0]  run_y[$];
    bit          cons_x, cons_y;

    task automatic model_reset();
        m_word   = 32'h0400_8080;
        m_facing = 1'b1;
        m_a = 0; m_b = 0; m_jump = 0; m_shield = 0;
        m_a_prev = 0; m_mask = 0;
        run_x.delete(); run_y.delete();
        cons_x = 0; cons_y = 0;
    endtask

    // An axis can smash if, in the current non-neutral run, the first extreme was
    // reached within FLICK samples, the stick stayed on it since, fewer than WIN
    // samples have passed since, and no smash has used it yet.
    function automatic void axis_armed(input logic [2:0] run[$], input bit cons,
                                       output bit armed, output logic [2:0] dir);
        int f;
        armed = 0;
        dir   = 3'b000;
        f     = -1;
        if (cons) return;
        for (int i = 0; i < run.size(); i++)
            if (f < 0 && (run[i] == 3'b000 || run[i] == 3'b111)) f = i;
        if (f < 0 || f + 1 > int'(FLICK) || run.size() - f > int'(WIN)) return;
        for (int i = f + 1; i < run.size(); i++)
            if (run[i] != run[f]) return;
        armed = 1;
        dir   = run[f];
    endfunction

    task automatic model_sample(input logic [2:0] cx, input logic [2:0] cy);
        bit ax, ay, edge_a, sx, sy;
        logic [2:0] dx, dy;
        axis_armed(run_x, cons_x, ax, dx);
        axis_armed(run_y, cons_y, ay, dy);
        edge_a = m_a && !m_a_prev;
        sx = edge_a && ax;
        sy = edge_a && !ax && ay;
        if (cx == 3'b000) m_facing = 0;
        else if (cx == 3'b111) m_facing = 1;
        m_word        = '0;
        m_word[26]    = m_facing;
        m_word[23]    = sx && (dx == 3'b000);
        m_word[22]    = sx && (dx == 3'b111);
        m_word[21]    = sy && (dy == 3'b111);
        m_word[20]    = sy && (dy == 3'b000);
        m_word[19]    = m_shield;
        m_word[18]    = m_jump;
        m_word[17]    = m_b;
        m_word[16]    = m_a && !(sx || sy) && !m_mask;
        m_word[15:13] = cx;
        m_word[7:5]   = cy;
        if (sx || sy) m_mask = 1;
        else if (!m_a) m_mask = 0;
        m_a_prev = m_a;
        if (cx == 3'b011 || cx == 3'b100) begin run_x.delete(); cons_x = 0; end
        else begin run_x.push_back(cx); if (sx) cons_x = 1; end
        if (cy == 3'b011 || cy == 3'b100) begin run_y.delete(); cons_y = 0; end
        else begin run_y.push_back(cy); if (sy) cons_y = 1; end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit sv, input logic [7:0] x, input logic [7:0] y);
        @(negedge clock);
        sample_valid = sv;
        joy_x = x;
        joy_y = y;
        @(posedge clock);
        #1;
        if (sv) model_sample(x[7:5], y[7:5]);
        chk("valid", 32'(controls_valid), 32'(sv));
        chk("controls", controls, m_word);
    endtask

    // Idle cycles long enough for every button to finish debouncing
    task automatic settle(input int n);
        repeat (n) step(0, joy_x, joy_y);
        m_a = btn_a_raw; m_b = btn_b_raw; m_jump = btn_jump_raw; m_shield = btn_shield_raw;
    endtask

    task automatic do_reset();
        @(negedge clock);
        sample_valid = 0;
        reset = 0;
        #1;
        chk("reset_controls", controls, 32'h0400_8080);
        chk("reset_valid", 32'(controls_valid), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1;
        model_reset();
    endtask

    initial begin
        model_reset();
        // Reset with no stimulus
        repeat (2) @(posedge clock);
        #1;
        chk("reset_controls", controls, 32'h0400_8080);
        @(negedge clock);
        reset = 1;
        repeat (20) step(0, 8'd128, 8'd128);

        // Debounce: short glitch must not register
        @(negedge clock);
        sample_valid = 1;
        btn_a_raw = 1;
        repeat (30) begin @(posedge clock); #1; chk("glitch_a", 32'(controls[16]), 32'd0); end
        @(negedge clock);
        btn_a_raw = 0;
        repeat (80) begin @(posedge clock); #1; chk("glitch_a", 32'(controls[16]), 32'd0); end
        // Five edges 100 cycles apart ending high; 2 sync + DEB stable + output register
        @(negedge clock);
        btn_a_raw = 1;
        for (int e = 0; e < 4; e++) begin
            repeat (100) @(negedge clock);
            btn_a_raw = ~btn_a_raw;
        end
        for (int k = 1; k <= int'(DEB) + 6; k++) begin
            @(posedge clock);
            #1;
            chk("deb_rise", 32'(controls[16]), 32'(k >= int'(DEB) + 3));
        end
        @(negedge clock);
        btn_a_raw = 0;
        sample_valid = 0;
        repeat (80) @(negedge clock);
        do_reset();

        // Fast flick left, then A
        step(1, 8'd128, 8'd128);
        step(1, 8'd60, 8'd128);
        step(1, 8'd0, 8'd128);
        btn_a_raw = 1;
        settle(80);
        step(1, 8'd0, 8'd128);
        chk("smashL", 32'(controls[23]), 32'd1);
        chk("smashL_a", 32'(controls[16]), 32'd0);
        chk("smashL_facing", 32'(controls[26]), 32'd0);
        step(1, 8'd0, 8'd128);
        chk("after_smash", 32'(controls[23]), 32'd0);
        chk("after_smash_a", 32'(controls[16]), 32'd0);
        btn_a_raw = 0;
        settle(80);
        step(1, 8'd128, 8'd128);

        // Slow approach: extreme reached on the 4th sample out of neutral
        step(1, 8'd96, 8'd128);
        step(1, 8'd80, 8'd128);
        step(1, 8'd60, 8'd128);
        step(1, 8'd40, 8'd128);
        step(1, 8'd0, 8'd128);
        btn_a_raw = 1;
        settle(80);
        step(1, 8'd0, 8'd128);
        chk("slow_a", 32'(controls[16]), 32'd1);
        chk("slow_smash", 32'(controls[23:20]), 32'd0);
        btn_a_raw = 0;
        settle(80);
        step(1, 8'd128, 8'd128);

        // X and Y flick together: X wins
        step(1, 8'd255, 8'd255);
        btn_a_raw = 1;
        settle(80);
        step(1, 8'd255, 8'd255);
        chk("both_smash", 32'(controls[23:20]), 32'b0100);
        chk("both_xcode", 32'(controls[15:13]), 32'b111);
        btn_a_raw = 0;
        settle(80);
        step(1, 8'd128, 8'd128);

        // Reset while X is armed leaves nothing pending
        step(1, 8'd0, 8'd128);
        do_reset();
        btn_a_raw = 1;
        settle(80);
        chk("post_reset_hold", controls, 32'h0400_8080);
        step(1, 8'd0, 8'd128);
        chk("post_reset_smash", 32'(controls[23:20]), 32'd0);
        chk("post_reset_a", 32'(controls[16]), 32'd1);
        btn_a_raw = 0;
        settle(80);

        // Random bursts of samples between button changes
        for (int b = 0; b < 40; b++) begin
            btn_a_raw      = 1'($urandom_range(0, 1));
            btn_b_raw      = 1'($urandom_range(0, 1));
            btn_jump_raw   = 1'($urandom_range(0, 1));
            btn_shield_raw = 1'($urandom_range(0, 1));
            settle(75);
            for (int s = 0; s < int'($urandom_range(1, 8)); s++) begin
                if ($urandom_range(0, 3) == 0) step(0, joy_x, joy_y);
                step(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
